inventory_arbiter: RTL and testbench
====================================

INVENTORY_ARBITER -- requirements
Module: inventory_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 8, inventory RAM address width; DW, default 16, inventory word width.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  2  request per requester; bit 0 is the MODBUS FSM, bit 1 is the dispense engine.
REQ-005 op  input  4  opcode per requester, {op1,op0}: 00 read, 01 write, 10 decrement-if-nonzero, 11 illegal.
REQ-006 addr  input  2*AW  address per requester, {addr1,addr0}.
REQ-007 wdata  input  2*DW  write data per requester, {wdata1,wdata0}.
REQ-008 gnt  output  2  one-hot grant, identifying the requester currently being served.
REQ-009 done  output  2  one-cycle completion pulse to the served requester.
REQ-010 rdata  output  DW  registered read data; valid while done is high.
REQ-011 fail  output  1  high with done on decrement-of-zero or an illegal opcode.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 ram_addr, ram_wdata, ram_we  output  AW, DW, 1  drive RAM port A.
REQ-014 ram_rdata  input  DW  RAM port A read data, valid one cycle after ram_addr is presented.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, MODIFY and DONE; exactly one transaction SHALL be in flight at a time.
REQ-016 In IDLE with any req bit high, the arbiter SHALL latch the winner's op, addr and wdata, set gnt, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: when both req bits are high, the requester not served last wins; after reset, requester 0 is favoured.
REQ-018 Read sequence: IDLE->ISSUE (ram_addr driven, ram_we=0)->WAIT (ram_rdata captured into rdata)->DONE.
REQ-019 Write sequence: IDLE->ISSUE (ram_we=1 for exactly one cycle, ram_wdata=latched wdata)->DONE.
REQ-020 Decrement sequence: IDLE->ISSUE->WAIT (capture old value)->MODIFY->DONE.
REQ-021 In MODIFY, if old value!=0, ram_we SHALL be 1 with ram_wdata=old-1 (DW-bit, no wrap); if old==0, ram_we SHALL stay 0 and fail SHALL assert in DONE.
REQ-022 On a decrement, rdata SHALL return the pre-decrement value.
REQ-023 Illegal op SHALL go IDLE->DONE with fail=1, no RAM access, and rdata unchanged.
REQ-024 Latency from the IDLE sampling edge to the done cycle SHALL be: write 2, read 3, decrement 4, illegal 1 cycles.
REQ-025 gnt SHALL stay constant from ISSUE through DONE; done[i] SHALL be high only in DONE, only for the granted i.
REQ-026 DONE SHALL always return to IDLE; a req still high in IDLE SHALL be arbitrated as a new request (no back-to-back grant without an IDLE cycle).
REQ-027 Deasserting req, or changing op/addr/wdata, mid-transaction SHALL be ignored; the latched transaction completes and done still pulses.
REQ-028 ram_we SHALL be 0 in IDLE, WAIT and DONE; ram_addr SHALL hold the latched address from ISSUE through MODIFY.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in IDLE and gnt, done, fail, busy and ram_we SHALL be 0; rdata, ram_addr and ram_wdata SHALL be 0.
REQ-030 The round-robin pointer SHALL reset to favour requester 0.
REQ-031 Reset mid-transaction SHALL abort it with no done pulse; a RAM write SHALL occur only if its ISSUE/MODIFY edge completed before reset asserted.

Verification
REQ-032 Write then read: requester 0 writes 0x0005 to addr 0x01, then reads addr 0x01 -> write done at +2, read done at +3, rdata=0x0005, fail=0.
REQ-033 Decrement: addr 0x01 holds 0x0005; requester 1 issues decrement -> ram_we once with 0x0004, done at +4, rdata=0x0005, fail=0.
REQ-034 Decrement of zero: addr 0x02 holds 0x0000; requester 1 issues decrement -> no ram_we, done with fail=1, rdata=0x0000.
REQ-035 Contention: both req held high continuously -> grants alternate 0,1,0,1 after reset, with one IDLE cycle between transactions.
REQ-036 Illegal op 11 from requester 0 -> done 1 cycle after the sampling edge, fail=1, ram_we never asserted.
REQ-037 Reset asserted in WAIT of a decrement -> outputs 0 immediately, no done, RAM word unchanged; after release the first request is served normally.

Source files
------------

// File: rtl/inventory_arbiter.sv
// -----------------------------------------------------------------------------
// inventory_arbiter
//
// Shares port A of the inventory RAM between two requesters: the MODBUS FSM
// (requester 0) and the dispense engine (requester 1). Exactly one transaction
// is in flight at a time. Supported operations are read, write and an atomic
// decrement-if-nonzero.
//
// Handshake: a requester raises req[i] with op/addr/wdata stable. The request
// is accepted on a rising edge where the arbiter is idle, and gnt[i] then
// identifies the accepted requester. Completion is a single-cycle done[i]
// pulse, with rdata/fail valid in that same cycle. After acceptance, req/op/
// addr/wdata are ignored until the arbiter is idle again. A req still high in
// the idle cycle is treated as a new request.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req[1:0]          request per requester
//   op[3:0]           {op1,op0}: 00 read, 01 write, 10 decrement, 11 illegal
//   addr[2*AW-1:0]    {addr1,addr0}
//   wdata[2*DW-1:0]   {wdata1,wdata0}
//   gnt[1:0]          one-hot grant, held from ISSUE through DONE
//   done[1:0]         one-cycle completion pulse to the served requester
//   rdata[DW-1:0]     registered read data (pre-decrement value on decrement)
//   fail              with done: decrement of zero or illegal opcode
//   busy              high whenever the FSM is not in IDLE
//   ram_addr/ram_wdata/ram_we  RAM port A controls
//   ram_rdata         RAM port A read data, one cycle after ram_addr
//   dbg_state[2:0]    current FSM state encoding
// -----------------------------------------------------------------------------
module inventory_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [3:0]      op,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            fail,
    output logic            busy,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    output logic            ram_we,
    input  logic [DW-1:0]   ram_rdata,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_MODIFY = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t      state;
    logic [1:0]  op_q;
    logic        last_idx;   // index of the requester served most recently

    // Winner selection, evaluated every cycle but only used in IDLE.
    logic          pick;
    logic [1:0]    win_op;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = ~last_idx;     // contention: whoever was not served last
        end else begin
            pick = req[1];        // single request (or none)
        end
        win_op    = pick ? op[3:2]          : op[1:0];
        win_addr  = pick ? addr[2*AW-1:AW]  : addr[AW-1:0];
        win_wdata = pick ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_RD;
            last_idx  <= 1'b1;    // so requester 0 wins the first contention
            gnt       <= 2'b00;
            done      <= 2'b00;
            rdata     <= '0;
            fail      <= 1'b0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ram_we <= 1'b0;
                    done   <= 2'b00;
                    fail   <= 1'b0;
                    if (req != 2'b00) begin
                        op_q     <= win_op;
                        gnt      <= pick ? 2'b10 : 2'b01;
                        last_idx <= pick;
                        busy     <= 1'b1;
                        if (win_op == OP_ILL) begin
                            // No RAM access; rdata and RAM port left untouched.
                            state <= S_DONE;
                            done  <= pick ? 2'b10 : 2'b01;
                            fail  <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            ram_addr  <= win_addr;
                            ram_wdata <= win_wdata;
                            ram_we    <= (win_op == OP_WR);
                        end
                    end
                end

                S_ISSUE: begin
                    ram_we <= 1'b0;
                    if (op_q == OP_WR) begin
                        state <= S_DONE;
                        done  <= gnt;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    rdata <= ram_rdata;
                    if (op_q == OP_DEC) begin
                        // Write back old-1 only when old is nonzero.
                        state     <= S_MODIFY;
                        ram_we    <= (ram_rdata != '0);
                        ram_wdata <= (ram_rdata != '0) ? (ram_rdata - ONE) : '0;
                    end else begin
                        state <= S_DONE;
                        done  <= gnt;
                    end
                end

                S_MODIFY: begin
                    ram_we <= 1'b0;
                    fail   <= (rdata == '0);
                    done   <= gnt;
                    state  <= S_DONE;
                end

                S_DONE: begin
                    ram_we <= 1'b0;
                    done   <= 2'b00;
                    fail   <= 1'b0;
                    gnt    <= 2'b00;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    ram_we <= 1'b0;
                    done   <= 2'b00;
                    fail   <= 1'b0;
                    gnt    <= 2'b00;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inventory_arbiter.sv
module tb_inventory_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [15:0] rdata;
    logic        fail;
    logic        busy;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [2:0]  dbg_state;

    int checks;
    int failures;

    // Expected record: {check_rdata, latency[3:0], gnt[1:0], fail, rdata[15:0]}
    logic [23:0] exp_q[$];
    logic [23:0] e;

    // Observations collected by wait_done
    int          obs_lat;
    int          obs_we_cnt;
    logic [15:0] obs_we_data;
    logic [22:0] obs_vec;

    logic [15:0] model [0:255];
    logic [15:0] mem   [0:255];

    inventory_arbiter #(.AW(8), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .fail      (fail),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] exp_pack(input bit chk, input int lat,
                                            input logic [1:0] g, input logic f,
                                            input logic [15:0] rd);
        return {chk, 4'(lat), g, f, rd};
    endfunction

    // ---------------- driver tasks ----------------
    // Waits for the arbiter to be idle, then presents one request.
    task automatic send(input int r, input logic [1:0] o, input logic [7:0] a,
                        input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req = 2'b00;
        req[r] = 1'b1;
        op[r*2 +: 2]    = o;
        addr[r*8 +: 8]  = a;
        wdata[r*16 +: 16] = d;
    endtask

    // Follows the request from its sampling edge to the done pulse, scrambling
    // the inputs after acceptance. Latency counts edges from the sampling edge.
    task automatic wait_done();
        obs_we_cnt  = 0;
        obs_we_data = 16'h0;
        @(posedge clk);
        #1;
        req   = 2'b00;
        op    = 4'($urandom);
        addr  = 16'($urandom);
        wdata = $urandom;
        obs_lat = 1;
        if (ram_we === 1'b1) begin obs_we_cnt++; obs_we_data = ram_wdata; end
        while (done === 2'b00 && obs_lat < 12) begin
            @(posedge clk);
            #1;
            obs_lat++;
            if (ram_we === 1'b1) begin obs_we_cnt++; obs_we_data = ram_wdata; end
        end
        obs_vec = {4'(obs_lat), gnt, fail, rdata};
        if (done !== gnt) begin
            checks++;
            failures++;
            $display("FAIL done_vs_gnt: done=%b gnt=%b", done, gnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b11;
        op    = 4'b0101;
        addr  = 16'h0201;
        wdata = 32'h0009_0008;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, done, rdata, fail, busy, ram_addr, ram_wdata, ram_we, dbg_state} !== 50'h0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b done=%b rdata=%h fail=%b busy=%b ram_addr=%h ram_wdata=%h ram_we=%b state=%0d, required all zero",
                     gnt, done, rdata, fail, busy, ram_addr, ram_wdata, ram_we, dbg_state);
        end
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        int n;
        logic [1:0] g_exp;
        exp_q.push_back(exp_pack(1'b0, 3, 2'b01, 1'b0, 16'h0));
        exp_q.push_back(exp_pack(1'b0, 3, 2'b10, 1'b0, 16'h0));
        exp_q.push_back(exp_pack(1'b0, 3, 2'b01, 1'b0, 16'h0));
        exp_q.push_back(exp_pack(1'b0, 3, 2'b10, 1'b0, 16'h0));
        @(negedge clk);
        req  = 2'b11;
        op   = 4'b0000;
        addr = 16'h0504;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (done === 2'b00 && n < 12) begin
                @(posedge clk);
                #1;
                n++;
            end
            e = exp_q.pop_front();
            g_exp = e[18:17];
            checks++;
            if (gnt !== g_exp || done !== g_exp) begin
                failures++;
                $display("FAIL contention_grant[%0d]: gnt=%b done=%b required %b", k, gnt, done, g_exp);
            end
            if (k == 3) req = 2'b00;
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 2'b00 || gnt !== 2'b00) begin
                failures++;
                $display("FAIL contention_idle_gap[%0d]: busy=%b done=%b gnt=%b required 0/00/00", k, busy, done, gnt);
            end
        end
    endtask

    task automatic test_write_read();
        exp_q.push_back(exp_pack(1'b0, 2, 2'b01, 1'b0, 16'h0));
        send(0, 2'b01, 8'h01, 16'h0005);
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec[22:16] !== e[22:16]) begin
            failures++;
            $display("FAIL write_txn: lat/gnt/fail/rdata=%h required %h", obs_vec, e[22:0]);
        end
        checks++;
        if (obs_we_cnt !== 1 || obs_we_data !== 16'h0005) begin
            failures++;
            $display("FAIL write_ram_we: pulses=%0d data=%h required 1 pulse of 0005", obs_we_cnt, obs_we_data);
        end
        exp_q.push_back(exp_pack(1'b1, 3, 2'b01, 1'b0, 16'h0005));
        send(0, 2'b00, 8'h01, 16'h0000);
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e[22:0] || obs_we_cnt !== 0) begin
            failures++;
            $display("FAIL read_txn: lat/gnt/fail/rdata=%h we=%0d required %h we=0", obs_vec, obs_we_cnt, e[22:0]);
        end
    endtask

    task automatic test_decrement();
        exp_q.push_back(exp_pack(1'b1, 4, 2'b10, 1'b0, 16'h0005));
        send(1, 2'b10, 8'h01, 16'h0000);
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e[22:0]) begin
            failures++;
            $display("FAIL dec_txn: lat/gnt/fail/rdata=%h required %h", obs_vec, e[22:0]);
        end
        checks++;
        if (obs_we_cnt !== 1 || obs_we_data !== 16'h0004 || mem[1] !== 16'h0004) begin
            failures++;
            $display("FAIL dec_writeback: pulses=%0d data=%h mem=%h required 1 pulse of 0004", obs_we_cnt, obs_we_data, mem[1]);
        end
    endtask

    task automatic test_illegal();
        // rdata still holds 0005 from the decrement and must not change.
        exp_q.push_back(exp_pack(1'b1, 1, 2'b01, 1'b1, 16'h0005));
        send(0, 2'b11, 8'h01, 16'h1234);
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e[22:0] || obs_we_cnt !== 0) begin
            failures++;
            $display("FAIL illegal_txn: lat/gnt/fail/rdata=%h we=%0d required %h we=0", obs_vec, obs_we_cnt, e[22:0]);
        end
        checks++;
        if (mem[1] !== 16'h0004) begin
            failures++;
            $display("FAIL illegal_no_write: mem[1]=%h required 0004", mem[1]);
        end
    endtask

    task automatic test_decrement_zero();
        exp_q.push_back(exp_pack(1'b1, 4, 2'b10, 1'b1, 16'h0000));
        send(1, 2'b10, 8'h02, 16'h0000);
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e[22:0] || obs_we_cnt !== 0 || mem[2] !== 16'h0000) begin
            failures++;
            $display("FAIL dec_zero: lat/gnt/fail/rdata=%h we=%0d mem=%h required %h we=0 mem=0000",
                     obs_vec, obs_we_cnt, mem[2], e[22:0]);
        end
    endtask

    task automatic test_random();
        int r;
        int o;
        logic [7:0]  a;
        logic [15:0] d;
        int exp_we;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 1);
            o = $urandom_range(0, 2);
            a = 8'($urandom_range(8, 10));
            d = 16'($urandom_range(0, 3));
            if (o == 0) begin
                exp_q.push_back(exp_pack(1'b1, 3, r ? 2'b10 : 2'b01, 1'b0, model[a]));
                exp_we = 0;
            end else if (o == 1) begin
                exp_q.push_back(exp_pack(1'b0, 2, r ? 2'b10 : 2'b01, 1'b0, 16'h0));
                model[a] = d;
                exp_we = 1;
            end else begin
                exp_q.push_back(exp_pack(1'b1, 4, r ? 2'b10 : 2'b01, model[a] == 16'h0, model[a]));
                exp_we = (model[a] != 16'h0) ? 1 : 0;
                if (model[a] != 16'h0) model[a] = model[a] - 16'h1;
            end
            send(r, 2'(o), a, d);
            wait_done();
            e = exp_q.pop_front();
            checks++;
            if ((e[23] ? (obs_vec !== e[22:0]) : (obs_vec[22:16] !== e[22:16])) || obs_we_cnt !== exp_we) begin
                failures++;
                $display("FAIL random[%0d] op=%0d addr=%h: lat/gnt/fail/rdata=%h we=%0d required %h we=%0d",
                         i, o, a, obs_vec, obs_we_cnt, e[22:0], exp_we);
            end
        end
        for (int k = 8; k <= 10; k++) begin
            checks++;
            if (mem[k] !== model[k]) begin
                failures++;
                $display("FAIL random_ram[%0d]: %h required %h", k, mem[k], model[k]);
            end
        end
    endtask

    task automatic test_reset_mid_txn();
        int seen_done;
        send(0, 2'b01, 8'h03, 16'h0007);
        wait_done();
        checks++;
        if (mem[3] !== 16'h0007) begin
            failures++;
            $display("FAIL prep_write: mem[3]=%h required 0007", mem[3]);
        end
        send(1, 2'b10, 8'h03, 16'h0000);
        @(posedge clk);   // sampling edge -> ISSUE
        #1;
        req = 2'b00;
        @(posedge clk);   // -> WAIT
        #1;
        checks++;
        if (dbg_state !== 3'd2) begin
            failures++;
            $display("FAIL mid_reset_in_wait: state=%0d required 2", dbg_state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, rdata, fail, busy, ram_addr, ram_wdata, ram_we, dbg_state} !== 50'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: gnt=%b done=%b rdata=%h fail=%b busy=%b ram_addr=%h ram_we=%b state=%0d, required all zero",
                     gnt, done, rdata, fail, busy, ram_addr, ram_we, dbg_state);
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 2'b00) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 2'b00) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || mem[3] !== 16'h0007) begin
            failures++;
            $display("FAIL mid_reset_abort: done_cycles=%0d mem[3]=%h required 0 and 0007", seen_done, mem[3]);
        end
        exp_q.push_back(exp_pack(1'b1, 3, 2'b10, 1'b0, 16'h0007));
        send(1, 2'b00, 8'h03, 16'h0000);
        wait_done();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e[22:0]) begin
            failures++;
            $display("FAIL post_reset_read: lat/gnt/fail/rdata=%h required %h", obs_vec, e[22:0]);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 16'h0;
            model[i] = 16'h0;
        end
        test_reset();
        test_contention();
        test_write_read();
        test_decrement();
        test_illegal();
        test_decrement_zero();
        test_random();
        test_reset_mid_txn();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
